// File: rtl/ula_pkg.sv
// Shared operation codes and word type for the 32-bit ALU.
package ula_pkg;

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_OR     = 3'b001;
  localparam logic [2:0] OP_ADDSUB = 3'b010;
  localparam logic [2:0] OP_SLT    = 3'b011;
  localparam logic [2:0] OP_XOR    = 3'b100;
  localparam logic [2:0] OP_NOR    = 3'b101;
  localparam logic [2:0] OP_SLTU   = 3'b110;
  localparam logic [2:0] OP_PASSB  = 3'b111;

  typedef logic [31:0] palavra_t;

endpackage

// File: rtl/ula_32_somador32.sv
// 32-bit adder/subtractor shared by ADD/SUB, SLT and SLTU.
module somador32
  import ula_pkg::*;
(
  input  palavra_t a,
  input  palavra_t b,
  input  logic     sub,
  output palavra_t soma,
  output logic     carry,
  output logic     ovf
);

  palavra_t b_eff;

  // Subtraction is a + ~b + 1; carry-out high means no borrow.
  assign b_eff          = sub ? ~b : b;
  assign {carry, soma}  = {1'b0, a} + {1'b0, b_eff} + {32'd0, sub};
  assign ovf            = (a[31] == b_eff[31]) && (soma[31] != a[31]);

endmodule

// File: rtl/ula_32.sv
// MIPS single-cycle ALU: combinational result/overflow/zero plus a sticky
// overflow status flop.
module ula_32
  import ula_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         ULAcontrole,
  input  logic [LARGURA-1:0] SrcA,
  input  logic [LARGURA-1:0] SrcB,
  input  logic               addSub,
  output logic [LARGURA-1:0] ULAsaida,
  output logic               overflow,
  output logic               zero,
  output logic               overflow_acum
);

  palavra_t soma;
  logic     carry;
  logic     ovf_add;
  logic     sub;
  logic     slt;
  logic     sltu;

  // Comparisons always need A - B; addSub only matters for ADD/SUB.
  assign sub = (ULAcontrole == OP_ADDSUB) ? addSub : 1'b1;

  somador32 u_somador (
    .a     (SrcA),
    .b     (SrcB),
    .sub   (sub),
    .soma  (soma),
    .carry (carry),
    .ovf   (ovf_add)
  );

  // N xor V keeps SLT correct when A - B overflows.
  assign slt  = soma[31] ^ ovf_add;
  assign sltu = ~carry;

  always_comb begin
    ULAsaida = '0;
    case (ULAcontrole)
      OP_AND:    ULAsaida = SrcA & SrcB;
      OP_OR:     ULAsaida = SrcA | SrcB;
      OP_ADDSUB: ULAsaida = soma;
      OP_SLT:    ULAsaida = LARGURA'(slt);
      OP_XOR:    ULAsaida = SrcA ^ SrcB;
      OP_NOR:    ULAsaida = ~(SrcA | SrcB);
      OP_SLTU:   ULAsaida = LARGURA'(sltu);
      default:   ULAsaida = SrcB;
    endcase
  end

  assign overflow = (ULAcontrole == OP_ADDSUB) && ovf_add;
  assign zero     = ~|ULAsaida;

  always_ff @(posedge clk) begin
    if (rst)           overflow_acum <= 1'b0;
    else if (overflow) overflow_acum <= 1'b1;
  end

endmodule

// File: tb/tb_ula_32.sv
// Self-checking bench for ula_32: directed spec vectors plus randomized
// stimulus against an arithmetic reference model, and sticky-flag tracking.
module tb_ula_32;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ULAcontrole;
  logic [31:0] SrcA, SrcB;
  logic        addSub;
  logic [31:0] ULAsaida;
  logic        overflow, zero, overflow_acum;

  int errors = 0;
  int checks = 0;
  logic acc_model = 1'b0;

  typedef struct {
    logic [2:0]  op;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ov;
  } vec_t;

  ula_32 #(.LARGURA(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ULAcontrole   (ULAcontrole),
    .SrcA          (SrcA),
    .SrcB          (SrcB),
    .addSub        (addSub),
    .ULAsaida      (ULAsaida),
    .overflow      (overflow),
    .zero          (zero),
    .overflow_acum (overflow_acum)
  );

  always #5 clk = ~clk;

  // Reference: signed overflow = true sum not representable in 32 bits.
  function automatic void model(input logic [2:0] op, input logic s,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov);
    longint sa, sb, t;
    logic [31:0] lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    r  = 32'd0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        t  = s ? sa - sb : sa + sb;
        lo = t[31:0];
        r  = lo;
        ov = (t != longint'($signed(lo)));
      end
      3'd3: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: r = ~(a | b);
      3'd6: r = (a < b) ? 32'd1 : 32'd0;
      default: r = b;
    endcase
  endfunction

  task automatic apply(input logic [2:0] op, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ULAcontrole = op; addSub = s; SrcA = a; SrcB = b;
    #1;
  endtask

  task automatic run_table(input string name, input vec_t v[]);
    foreach (v[i]) begin
      apply(v[i].op, v[i].s, v[i].a, v[i].b);
      checks++;
      if (ULAsaida !== v[i].r) begin
        errors++;
        $display("FAIL %s[%0d] result: got %h want %h", name, i, ULAsaida, v[i].r);
      end
      checks++;
      if (overflow !== v[i].ov) begin
        errors++;
        $display("FAIL %s[%0d] overflow: got %b want %b", name, i, overflow, v[i].ov);
      end
      checks++;
      if (zero !== (v[i].r == 32'd0)) begin
        errors++;
        $display("FAIL %s[%0d] zero: got %b want %b", name, i, zero, v[i].r == 32'd0);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(3'b000, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00);
    checks++;
    if (ULAsaida !== 32'hF000F000) begin
      errors++;
      $display("FAIL reset_comb: got %h want %h", ULAsaida, 32'hF000F000);
    end
    @(posedge clk); #1;
    acc_model = 1'b0;
    checks++;
    if (overflow_acum !== 1'b0) begin
      errors++;
      $display("FAIL reset_acum: got %b want 0", overflow_acum);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    vec_t v[] = '{
      '{3'b010, 1'b0, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0},
      '{3'b010, 1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0},
      '{3'b010, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1},
      '{3'b010, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1},
      '{3'b010, 1'b1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0}
    };
    run_table("add_sub", v);
  endtask

  task automatic test_logic();
    vec_t v[] = '{
      '{3'b000, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0},
      '{3'b000, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0},
      '{3'b001, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0},
      '{3'b001, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0},
      '{3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0},
      '{3'b100, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0},
      '{3'b101, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0},
      '{3'b101, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0}
    };
    run_table("logic", v);
  endtask

  task automatic test_slt();
    vec_t v[] = '{
      '{3'b011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0},
      '{3'b110, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
      '{3'b011, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0},
      '{3'b110, 1'b1, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b0},
      '{3'b011, 1'b1, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0},
      '{3'b110, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0}
    };
    run_table("slt", v);
  endtask

  task automatic test_passb();
    vec_t v[] = '{
      '{3'b111, 1'b0, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0},
      '{3'b111, 1'b1, 32'h7FFFFFFF, 32'h00000000, 32'h00000000, 1'b0}
    };
    run_table("passb", v);
  endtask

  task automatic check_acum(input string name, input logic want);
    checks++;
    if (overflow_acum !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, overflow_acum, want);
    end
  endtask

  task automatic test_sticky();
    rst = 1'b1;
    apply(3'b010, 1'b0, 32'd1, 32'd2);
    @(posedge clk); #1;
    check_acum("sticky_rst", 1'b0);
    rst = 1'b0;
    apply(3'b010, 1'b0, 32'h7FFFFFFF, 32'd1);
    @(posedge clk); #1;
    check_acum("sticky_set", 1'b1);
    apply(3'b010, 1'b0, 32'd5, 32'd3);
    @(posedge clk); #1;
    check_acum("sticky_hold", 1'b1);
    apply(3'b000, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    check_acum("sticky_hold2", 1'b1);
    // rst wins over a simultaneous overflow; comb outputs still live
    rst = 1'b1;
    apply(3'b010, 1'b0, 32'h7FFFFFFF, 32'd1);
    checks++;
    if (overflow !== 1'b1 || ULAsaida !== 32'h80000000) begin
      errors++;
      $display("FAIL rst_comb: got %h/%b want 80000000/1", ULAsaida, overflow);
    end
    @(posedge clk); #1;
    check_acum("sticky_rst_prio", 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_acum("sticky_reset_again", 1'b1);
    acc_model = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] a, b, r;
    logic [2:0]  op;
    logic        s, ov;
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      s  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: a = 32'h7FFFFFFF - 32'($urandom_range(0, 3));
        1: a = 32'h80000000 + 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      rst = ($urandom_range(0, 15) == 0);
      model(op, s, a, b, r, ov);
      apply(op, s, a, b);
      checks++;
      if (ULAsaida !== r || overflow !== ov || zero !== (r == 32'd0)) begin
        errors++;
        $display("FAIL random[%0d] op=%b s=%b a=%h b=%h: got %h/%b/%b want %h/%b/%b",
                 i, op, s, a, b, ULAsaida, overflow, zero, r, ov, r == 32'd0);
      end
      @(posedge clk); #1;
      acc_model = rst ? 1'b0 : (acc_model | ov);
      checks++;
      if (overflow_acum !== acc_model) begin
        errors++;
        $display("FAIL random_acum[%0d]: got %b want %b", i, overflow_acum, acc_model);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ULAcontrole = 3'b000; addSub = 1'b0; SrcA = '0; SrcB = '0;
    test_reset();
    test_add_sub();
    test_logic();
    test_slt();
    test_passb();
    test_sticky();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ula_32.md
Name: ula_32

Overview:
- 32-bit ALU for the single-cycle MIPS datapath. Operation is selected by a 3-bit control code plus an add/subtract flag.
- Produces a 32-bit result, a signed-overflow flag and a zero flag, all purely combinational.
- Adds one clocked element: a sticky overflow status bit for debug and exception logic.

Parameters:
- LARGURA, 32, datapath width. Only 32 is verified.

Ports:
- clk  in  1  system clock; clocks only the sticky status register.
- rst  in  1  synchronous, active-high reset.
- ULAcontrole  in  3  operation select (encoding below).
- SrcA  in  32  operand A.
- SrcB  in  32  operand B.
- addSub  in  1  for ULAcontrole=010 only: 0 = add, 1 = subtract.
- ULAsaida  out  32  result, combinational.
- overflow  out  1  signed overflow of the current add/sub, combinational.
- zero  out  1  high when ULAsaida == 0, combinational.
- overflow_acum  out  1  sticky overflow, registered.

Behaviour:
- Timing
  - ULAsaida, overflow and zero are pure combinational functions of ULAcontrole, SrcA, SrcB and addSub.
  - Zero latency; settled well within half a clock period.
  - Not affected by clk or rst.
- Operation encoding
  - 000 AND: A & B
  - 001 OR: A | B
  - 010 ADD/SUB: A + B if addSub=0, A - B if addSub=1 (A + ~B + 1); result modulo 2^32.
  - 011 SLT: 32'd1 if A < B signed, else 0. Computed from the subtraction as N xor V, so it is correct even when A-B overflows.
  - 100 XOR: A ^ B
  - 101 NOR: ~(A | B)
  - 110 SLTU: 32'd1 if A < B unsigned (borrow of A - B), else 0.
  - 111 pass B: ULAsaida = SrcB.
- addSub is ignored for every code except 010.
- overflow
  - Code 010 add: (A[31] == B[31]) && (R[31] != A[31]).
  - Code 010 sub: (A[31] != B[31]) && (R[31] != A[31]).
  - Forced to 0 for all other codes, including SLT/SLTU.
- zero: NOR-reduction of ULAsaida; valid for every operation.
- No X propagation: every code, including 111, yields a defined result.
- overflow_acum
  - At each posedge clk: if rst then 0; else if overflow then 1; else hold.
  - Reset value is 0. rst has priority over a simultaneous overflow.
  - Once set, it clears only on rst.
- Reset has no effect on the combinational outputs. During rst they still track their inputs.

Decomposition:
- Shared package ula_pkg:
  - Constants OP_AND=3'b000, OP_OR=3'b001, OP_ADDSUB=3'b010, OP_SLT=3'b011, OP_XOR=3'b100, OP_NOR=3'b101, OP_SLTU=3'b110, OP_PASSB=3'b111.
  - Typedef palavra_t = logic [31:0].
- One natural sub-module: somador32, a 32-bit adder/subtractor.
  - Inputs a, b, sub.
  - Outputs soma, carry-out, signed overflow.
  - Shared by ADD/SUB, SLT and SLTU.
- Logic ops and the output mux stay in ula_32, as does the overflow_acum flop.

Test Plan:
- ADD 010, addSub=0, A=0x00000005, B=0x00000003 -> ULAsaida=0x00000008, overflow=0, zero=0.
- SUB and overflow cases:
  - 010, addSub=1, A=B=0x12345678 -> ULAsaida=0, zero=1, overflow=0.
  - 010, addSub=0, A=0x7FFFFFFF, B=1 -> ULAsaida=0x80000000, overflow=1.
  - 010, addSub=1, A=0x80000000, B=1 -> ULAsaida=0x7FFFFFFF, overflow=1.
- Logic ops, A=0xF0F0F0F0, B=0xFF00FF00:
  - AND -> 0xF000F000
  - OR -> 0xFFF0FFF0
  - XOR -> 0x0FF00FF0
  - NOR -> 0x000F000F
  - Each with overflow=0. With addSub toggled, results are unchanged.
- SLT/SLTU with A=0xFFFFFFFF, B=1:
  - SLT -> 1, zero=0.
  - SLTU -> 0, zero=1.
  - SLT with A=0x80000000, B=0x7FFFFFFF (overflowing subtraction) -> 1, overflow=0.
- overflow_acum:
  - rst=1 for one cycle -> 0.
  - Apply the 0x7FFFFFFF+1 add, then a clean add -> overflow_acum=1 from the first posedge and stays 1.
  - rst=1 in the same cycle as an overflowing add -> 0 after that edge.
- Pass B 111, SrcB=0xDEADBEEF -> ULAsaida=0xDEADBEEF, overflow=0.
- Pass B 111, SrcB=0 -> zero=1.
